mix_columns: RTL and testbench

//  AES MixColumns round stage: GF(2^8) 4x4 matrix multiply on each of the four state columns.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/mix_single_column.sv | 43 ++++
 rtl/mix_columns.sv | 42 ++++
 tb/tb_mix_columns.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers shared by the MixColumns stage.
// Optional macro INV_MIXCOL_EN adds the inverse-matrix multipliers.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul3(input byte_t x);
    return xtime(x) ^ x;
  endfunction

`ifdef INV_MIXCOL_EN
  function automatic byte_t gmul9(input byte_t x);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic byte_t gmul11(input byte_t x);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic byte_t gmul13(input byte_t x);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic byte_t gmul14(input byte_t x);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
`endif

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column, row 0 in col[31:24].
// Ports: col in, res out; inv selects inverse (macro INV_MIXCOL_EN).
module mix_single_column
  import aes_pkg::*;
(
`ifdef INV_MIXCOL_EN
  input  logic inv,
`endif
  input  col_t col,
  output col_t res
);

  byte_t a0, a1, a2, a3;
  col_t  fwd;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign fwd = {
    xtime(a0) ^ gmul3(a1) ^ a2 ^ a3,
    a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
    a0 ^ a1 ^ xtime(a2) ^ gmul3(a3),
    gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)
  };

`ifdef INV_MIXCOL_EN
  col_t bwd;

  assign bwd = {
    gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
    gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
    gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3),
    gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3)
  };

  assign res = inv ? bwd : fwd;
`else
  assign res = fwd;
`endif

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns round stage, one registered cycle of latency.
// Ports: clk, rst (async high), in_valid, inv (INV_MIXCOL_EN only),
// msg in, out_valid, cipher out. Byte 0 sits in msg[127:120].
module mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
`ifdef INV_MIXCOL_EN
  input  logic         inv,
`endif
  input  logic [127:0] msg,
  output logic         out_valid,
  output logic [127:0] cipher
);

  logic [127:0] mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    mix_single_column u_col (
`ifdef INV_MIXCOL_EN
      .inv (inv),
`endif
      .col (msg[127-32*c -: 32]),
      .res (mixed[127-32*c -: 32])
    );
  end

  // Data only loads on accepted states so idle msg cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        cipher <= mixed;
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: known vectors plus a
// random stream against a generic GF(2^8) matrix model.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] msg;
  logic         out_valid;
  logic [127:0] cipher;
  logic         inv = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_columns dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
`ifdef INV_MIXCOL_EN
    .inv       (inv),
`endif
    .msg       (msg),
    .out_valid (out_valid),
    .cipher    (cipher)
  );

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix: row r uses base coefficients rotated right by r.
  function automatic logic [127:0] ref_mc(
    input logic [127:0] m, input logic iv);
    logic [7:0] base [4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [127:0] o = '0;
    if (iv) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++)
        a[k] = m[127 - 32*c - 8*k -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++)
          b = b ^ gmul(base[(k - r + 4) % 4], a[k]);
        o[127 - 32*c - 8*r -: 8] = b;
      end
    end
    return o;
  endfunction

  task automatic check(input string name,
    input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v,
    input logic [127:0] m, input logic iv);
    in_valid = v;
    msg = m;
    inv = iv;
  endtask

  typedef struct {
    logic [127:0] m;
    logic [127:0] e;
  } vec_t;

  vec_t vecs [5];
  logic [127:0] held, r, exp_c, orig, fwdv;
  logic exp_v, v, iv;

  initial begin
    vecs[0] = '{128'h6353e08c0960e104cd70b751bacad0e7,
                128'h5f72641557f5bc92f7be3b291db9f91a};
    vecs[1] = '{128'ha7be1a6997ad739bd8c9ca451f618b61,
                128'hff87968431d86a51645151fa773ad009};
    vecs[2] = '{128'h3bd92268fc74fb735767cbe0c0590e2d,
                128'h4c9c1e66f771f0762c3f868e534df256};
    vecs[3] = '{128'hdb135345_00000000_00000000_00000000,
                128'h8e4da1bc_00000000_00000000_00000000};
    vecs[4] = '{128'h0, 128'h0};

    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_cipher", cipher, '0);
    check("reset_valid", {127'b0, out_valid}, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].m, 1'b0);
      @(negedge clk);
      drive(1'b0, '0, 1'b0);
      check($sformatf("vec%0d", i), cipher, vecs[i].e);
      check($sformatf("vec%0d_valid", i),
            {127'b0, out_valid}, 128'h1);
      check($sformatf("vec%0d_model", i),
            ref_mc(vecs[i].m, 1'b0), vecs[i].e);
    end

    // Back-to-back: two accepted states on consecutive edges.
    @(negedge clk);
    drive(1'b1, vecs[1].m, 1'b0);
    @(negedge clk);
    check("b2b_first", cipher, vecs[1].e);
    check("b2b_first_v", {127'b0, out_valid}, 128'h1);
    drive(1'b1, vecs[2].m, 1'b0);
    @(negedge clk);
    check("b2b_second", cipher, vecs[2].e);
    check("b2b_second_v", {127'b0, out_valid}, 128'h1);

    // Idle cycles with junk msg leave cipher alone.
    held = cipher;
    drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(negedge clk);
    check("idle_hold", cipher, held);
    check("idle_valid", {127'b0, out_valid}, 128'h0);
    msg = 'x;
    @(negedge clk);
    check("idle_x_hold", cipher, held);

    // Async reset with a pending input: clears before any edge,
    // and the pending state is dropped across the edge.
    drive(1'b1, vecs[0].m, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst", cipher, '0);
    check("async_rst_v", {127'b0, out_valid}, 128'h0);
    @(negedge clk);
    check("rst_drop", cipher, '0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef INV_MIXCOL_EN
    @(negedge clk);
    drive(1'b1, 128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check("inv_vec", cipher, 128'h6353e08c0960e104cd70b751bacad0e7);
    for (int n = 0; n < 8; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      drive(1'b1, orig, 1'b0);
      @(negedge clk);
      fwdv = cipher;
      drive(1'b1, fwdv, 1'b1);
      @(negedge clk);
      drive(1'b0, '0, 1'b0);
      check($sformatf("roundtrip%0d", n), cipher, orig);
    end
`endif

    // Random stream with random gaps against the model.
    @(negedge clk);
    exp_v = 1'b0;
    exp_c = cipher;
    for (int n = 0; n < 200; n++) begin
      v  = ($urandom_range(3) != 0);
      r  = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MIXCOL_EN
      iv = $urandom_range(1) == 1;
`else
      iv = 1'b0;
`endif
      drive(v, r, iv);
      if (v) exp_c = ref_mc(r, iv);
      exp_v = v;
      @(negedge clk);
      check($sformatf("rnd%0d", n), cipher, exp_c);
      check($sformatf("rnd%0d_v", n),
            {127'b0, out_valid}, {127'b0, exp_v});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
